dcache_snoop_ctrl: RTL and testbench

Per-core coherence responder and MSI state store for the data cache. Sits directly upstream of the memory controller on each core's `cc` port. It answers the controller's snoops (`ccwait`/`ccsnoopaddr`/`ccinv`) with `cctrans`/`ccwrite`, supplies the dirty block on a bus writeback, and keeps per-frame MSI state for the core's own cache FSM. One instance is built per core.

---
 rtl/cpu_types_pkg.sv | 26 ++
 rtl/msi_state_array.sv | 53 +++++
 rtl/dcache_snoop_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_dcache_snoop_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU/cache types: MSI coherence encoding, snoop FSM states and block geometry.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        MSI_I = 2'd0,
        MSI_S = 2'd1,
        MSI_M = 2'd2
    } msi_t;

    typedef enum logic [2:0] {
        SNP_IDLE,
        SNP_LOOKUP,
        SNP_RESPOND,
        SNP_WB,
        SNP_DONE
    } snoop_state_t;

    localparam int WORDS_PER_BLOCK = 2;
    localparam int BLOCK_OFF_BITS  = 3;

    // The unused encoding 3 carries no coherence meaning, so it is stored as I.
    function automatic msi_t msi_sanitize(input logic [1:0] v);
        return (v == 2'd3) ? MSI_I : msi_t'(v);
    endfunction

endpackage

// File: rtl/msi_state_array.sv
// Per-frame MSI state store: one CPU read port, one full-set snoop read port and a
// single write port where the snoop update overrides the CPU write.
module msi_state_array
    import cpu_types_pkg::*;
#(
    parameter int SETS = 8,
    parameter int WAYS = 2,
    localparam int SW = $clog2(SETS),
    localparam int WW = $clog2(WAYS)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [SW-1:0]     rd_set,
    input  logic [WW-1:0]     rd_way,
    output logic [1:0]        rd_state,
    input  logic [SW-1:0]     snp_set,
    output logic [WAYS*2-1:0] snp_states,
    input  logic              st_we,
    input  logic [SW-1:0]     st_set,
    input  logic [WW-1:0]     st_way,
    input  logic [1:0]        st_val,
    input  logic              upd_we,
    input  logic [SW-1:0]     upd_set,
    input  logic [WW-1:0]     upd_way,
    input  msi_t              upd_val
);

    msi_t mem [SETS][WAYS];

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    mem[s][w] <= MSI_I;
                end
            end
        end else if (upd_we) begin
            mem[upd_set][upd_way] <= upd_val;
        end else if (st_we) begin
            mem[st_set][st_way] <= msi_sanitize(st_val);
        end
    end

    assign rd_state = mem[rd_set][rd_way];

    always_comb begin
        snp_states = '0;
        for (int w = 0; w < WAYS; w++) begin
            snp_states[w*2 +: 2] = mem[snp_set][w];
        end
    end

endmodule

// File: rtl/dcache_snoop_ctrl.sv
// Per-core snoop responder: looks up snooped addresses, answers with cctrans/ccwrite,
// drains dirty blocks and maintains MSI state. Optional counters under SNOOP_STATS_EN.
module dcache_snoop_ctrl
    import cpu_types_pkg::*;
#(
    parameter int SETS = 8,
    parameter int WAYS = 2,
    parameter int TAGW = 32 - 3 - $clog2(SETS),
    localparam int SW = $clog2(SETS),
    localparam int WW = $clog2(WAYS)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 ccwait,
    input  logic                 ccinv,
    input  logic [31:0]          ccsnoopaddr,
    input  logic                 wb_ack,
    input  logic                 req_rdx,
    input  logic [WAYS*TAGW-1:0] tag_rd,
    input  logic [31:0]          snp_data,
    input  logic                 st_we,
    input  logic [SW-1:0]        st_set,
    input  logic [WW-1:0]        st_way,
    input  logic [1:0]           st_val,
    input  logic [SW-1:0]        rd_set,
    input  logic [WW-1:0]        rd_way,
    output logic                 cctrans,
    output logic                 ccwrite,
    output logic [31:0]          dstore_snp,
    output logic [SW-1:0]        snp_set,
    output logic [WW-1:0]        snp_way,
    output logic                 snp_word,
    output logic [1:0]           rd_state,
    output logic                 snp_busy
`ifdef SNOOP_STATS_EN
    ,
    output logic [15:0]          stat_hits,
    output logic [15:0]          stat_invs,
    output logic [15:0]          stat_wbs
`endif
);

    snoop_state_t state_q, state_d;
    logic            hit_q, dirty_q, inv_q, cnt_q;
    logic [WW-1:0]   way_q;
    logic [SW-1:0]   set_q;

    logic [SW-1:0]     lk_set;
    logic [TAGW-1:0]   lk_tag;
    logic [WAYS*2-1:0] snp_states;
    logic              lk_hit, lk_dirty;
    logic [WW-1:0]     lk_way;

    logic upd_we, st_we_idle;
    msi_t upd_val;

    logic unused_addr_bits;
    assign unused_addr_bits = ^ccsnoopaddr[2:0];

    assign lk_set = ccsnoopaddr[SW+2:3];
    assign lk_tag = ccsnoopaddr[31 -: TAGW];

    // Walk ways high to low so the lowest valid matching way is the one kept.
    always_comb begin
        lk_hit   = 1'b0;
        lk_dirty = 1'b0;
        lk_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (tag_rd[w*TAGW +: TAGW] == lk_tag && snp_states[w*2 +: 2] != MSI_I) begin
                lk_hit   = 1'b1;
                lk_way   = WW'(w);
                lk_dirty = (snp_states[w*2 +: 2] == MSI_M);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cctrans    = 1'b0;
        ccwrite    = req_rdx;
        dstore_snp = '0;
        snp_set    = '0;
        snp_way    = '0;
        snp_word   = 1'b0;
        upd_we     = 1'b0;
        upd_val    = MSI_I;
        case (state_q)
            SNP_IDLE: begin
                if (ccwait) state_d = SNP_LOOKUP;
            end
            SNP_LOOKUP: begin
                snp_set = lk_set;
                state_d = SNP_RESPOND;
            end
            SNP_RESPOND: begin
                snp_set = set_q;
                cctrans = 1'b1;
                ccwrite = hit_q && dirty_q;
                if (hit_q && dirty_q) begin
                    state_d = SNP_WB;
                end else begin
                    upd_we  = hit_q;
                    upd_val = ccinv ? MSI_I : MSI_S;
                    state_d = SNP_DONE;
                end
            end
            SNP_WB: begin
                snp_set    = set_q;
                snp_way    = way_q;
                snp_word   = cnt_q;
                ccwrite    = 1'b1;
                dstore_snp = snp_data;
                if (wb_ack && cnt_q) begin
                    upd_we  = 1'b1;
                    upd_val = inv_q ? MSI_I : MSI_S;
                    state_d = SNP_DONE;
                end
            end
            SNP_DONE: begin
                if (!ccwait) state_d = SNP_IDLE;
            end
            default: state_d = SNP_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= SNP_IDLE;
            hit_q   <= 1'b0;
            dirty_q <= 1'b0;
            inv_q   <= 1'b0;
            cnt_q   <= 1'b0;
            way_q   <= '0;
            set_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                SNP_LOOKUP: begin
                    hit_q   <= lk_hit;
                    dirty_q <= lk_dirty;
                    way_q   <= lk_way;
                    set_q   <= lk_set;
                end
                SNP_RESPOND: begin
                    inv_q <= ccinv;
                    cnt_q <= 1'b0;
                end
                SNP_WB: begin
                    if (wb_ack) cnt_q <= !cnt_q;
                end
                default: ;
            endcase
        end
    end

    assign snp_busy   = (state_q != SNP_IDLE);
    assign st_we_idle = st_we && (state_q == SNP_IDLE);

    msi_state_array #(
        .SETS(SETS),
        .WAYS(WAYS)
    ) u_states (
        .CLK        (CLK),
        .RST        (RST),
        .rd_set     (rd_set),
        .rd_way     (rd_way),
        .rd_state   (rd_state),
        .snp_set    (snp_set),
        .snp_states (snp_states),
        .st_we      (st_we_idle),
        .st_set     (st_set),
        .st_way     (st_way),
        .st_val     (st_val),
        .upd_we     (upd_we),
        .upd_set    (set_q),
        .upd_way    (way_q),
        .upd_val    (upd_val)
    );

`ifdef SNOOP_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            stat_hits <= '0;
            stat_invs <= '0;
            stat_wbs  <= '0;
        end else begin
            if (state_q == SNP_RESPOND && hit_q) stat_hits <= sat_inc(stat_hits);
            if (upd_we && upd_val == MSI_I)      stat_invs <= sat_inc(stat_invs);
            if (state_q == SNP_WB && wb_ack && cnt_q) stat_wbs <= sat_inc(stat_wbs);
        end
    end
`endif

endmodule

// File: tb/tb_dcache_snoop_ctrl.sv
// Scoreboard bench for dcache_snoop_ctrl: directed scenarios plus randomized snoops
// checked against a frame-level MSI model.
module tb_dcache_snoop_ctrl;

    localparam int SETS = 8;
    localparam int WAYS = 2;
    localparam int TAGW = 32 - 3 - $clog2(SETS);
    localparam int SW   = $clog2(SETS);
    localparam int WW   = $clog2(WAYS);

    logic                 CLK = 1'b0;
    logic                 RST;
    logic                 ccwait, ccinv, wb_ack, req_rdx, st_we;
    logic [31:0]          ccsnoopaddr;
    logic [WAYS*TAGW-1:0] tag_rd;
    logic [31:0]          snp_data;
    logic [SW-1:0]        st_set, rd_set, snp_set;
    logic [WW-1:0]        st_way, rd_way, snp_way;
    logic [1:0]           st_val, rd_state;
    logic                 cctrans, ccwrite, snp_word, snp_busy;
    logic [31:0]          dstore_snp;
`ifdef SNOOP_STATS_EN
    logic [15:0]          stat_hits, stat_invs, stat_wbs;
`endif

    dcache_snoop_ctrl #(.SETS(SETS), .WAYS(WAYS)) dut (
        .CLK(CLK), .RST(RST), .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
        .wb_ack(wb_ack), .req_rdx(req_rdx), .tag_rd(tag_rd), .snp_data(snp_data),
        .st_we(st_we), .st_set(st_set), .st_way(st_way), .st_val(st_val),
        .rd_set(rd_set), .rd_way(rd_way), .cctrans(cctrans), .ccwrite(ccwrite),
        .dstore_snp(dstore_snp), .snp_set(snp_set), .snp_way(snp_way),
        .snp_word(snp_word), .rd_state(rd_state), .snp_busy(snp_busy)
`ifdef SNOOP_STATS_EN
        , .stat_hits(stat_hits), .stat_invs(stat_invs), .stat_wbs(stat_wbs)
`endif
    );

    always #5 CLK = ~CLK;

    // Cache arrays outside the controller, plus the expected MSI state per frame.
    logic [TAGW-1:0] tag_mem  [SETS][WAYS];
    logic [31:0]     data_mem [SETS][WAYS][2];
    int              m_st     [SETS][WAYS];
    logic [TAGW-1:0] tag_pool [3];

    always_comb begin
        tag_rd = '0;
        for (int w = 0; w < WAYS; w++) tag_rd[w*TAGW +: TAGW] = tag_mem[snp_set][w];
    end
    assign snp_data = data_mem[snp_set][snp_way][snp_word];

    int n_pass = 0;
    int n_total = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endfunction

    logic        resp_q [$];
    logic [31:0] wb_q   [$];
    logic [1:0]  rd_q   [$];
    logic        ack_chk = 1'b0;
    logic        rd_chk  = 1'b0;

    // Monitor: pops an expectation whenever the DUT responds, drains a word, or a read is probed.
    always @(negedge CLK) begin
        if (cctrans) begin
            if (resp_q.size() == 0) chk("unexpected_cctrans", 32'd1, 32'd0);
            else chk("ccwrite_resp", {31'b0, ccwrite}, {31'b0, resp_q.pop_front()});
        end
        if (ack_chk) begin
            if (wb_q.size() == 0) chk("unexpected_wb_word", 32'd1, 32'd0);
            else chk("dstore_snp", dstore_snp, wb_q.pop_front());
        end
        if (rd_chk) begin
            if (rd_q.size() == 0) chk("unexpected_rd", 32'd1, 32'd0);
            else chk("rd_state", {30'b0, rd_state}, {30'b0, rd_q.pop_front()});
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic read_frame(input int s, input int w);
        rd_set = SW'(s);
        rd_way = WW'(w);
        rd_q.push_back(2'(m_st[s][w]));
        rd_chk = 1'b1;
        tick();
        rd_chk = 1'b0;
    endtask

    task automatic read_all();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) read_frame(s, w);
    endtask

    task automatic set_frame(input int s, input int w, input int v, input logic [TAGW-1:0] tag);
        tag_mem[s][w] = tag;
        st_set = SW'(s);
        st_way = WW'(w);
        st_val = 2'(v);
        st_we  = 1'b1;
        #1;
        chk("ccwrite_idle", {31'b0, ccwrite}, {31'b0, req_rdx});
        tick();
        st_we = 1'b0;
        m_st[s][w] = (v == 3) ? 0 : v;
    endtask

    function automatic logic [31:0] mk_addr(input logic [TAGW-1:0] tag, input int s, input bit word);
        return {tag, 3'(s), word, 2'b00};
    endfunction

    task automatic snoop(input logic [31:0] addr, input bit inv, input int gap0, input int gap1,
                         input bit early, input int hold, input bit st_during);
        int  s, way, g;
        bit  hit, dirty;
        s = int'(addr[5:3]);
        hit = 0;
        way = 0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && tag_mem[s][w] == addr[31:6] && m_st[s][w] != 0) begin
                hit = 1;
                way = w;
            end
        end
        dirty = hit && (m_st[s][way] == 2);
        resp_q.push_back(dirty);

        ccwait = 1'b1;
        ccsnoopaddr = addr;
        ccinv  = 1'($urandom);
        wb_ack = 1'($urandom);
        tick();                               // LOOKUP
        if (early) ccwait = 1'b0;
        ccinv  = 1'($urandom);
        wb_ack = 1'($urandom);
        tick();                               // RESPOND
        ccinv  = inv;
        wb_ack = 1'($urandom);
        #1;
        chk("cctrans_latency", {31'b0, cctrans}, 32'd1);
        tick();
        ccinv  = 1'($urandom);
        wb_ack = 1'b0;
        if (dirty) begin
            if (st_during) begin
                st_set = SW'(s);
                st_way = WW'(way);
                st_val = 2'd2;
                st_we  = 1'b1;
            end
            for (int k = 0; k < 2; k++) begin
                g = (k == 0) ? gap0 : gap1;
                wb_ack = 1'b0;
                repeat (g) tick();
                wb_ack  = 1'b1;
                ack_chk = 1'b1;
                wb_q.push_back(data_mem[s][way][k]);
                tick();
                ack_chk = 1'b0;
                wb_ack  = 1'b0;
            end
            st_we = 1'b0;
        end
        if (hit) m_st[s][way] = inv ? 0 : 1;
        // First DONE cycle: the update must already be visible.
        rd_set = SW'(s);
        rd_way = WW'(way);
        rd_q.push_back(2'(m_st[s][way]));
        rd_chk = 1'b1;
        chk("busy_done", {31'b0, snp_busy}, 32'd1);
        tick();
        rd_chk = 1'b0;
        repeat (hold) tick();
        ccwait = 1'b0;
        tick();
        chk("busy_idle", {31'b0, snp_busy}, 32'd0);
    endtask

    initial begin
        RST = 1'b1; ccwait = 0; ccinv = 0; wb_ack = 0; req_rdx = 1; st_we = 0;
        ccsnoopaddr = '0; st_set = '0; st_way = '0; st_val = '0; rd_set = '0; rd_way = '0;
        tag_pool[0] = TAGW'(32'h40);
        tag_pool[1] = TAGW'(32'h1234);
        tag_pool[2] = TAGW'(32'h3_FFFF);
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                tag_mem[s][w] = tag_pool[$urandom_range(0, 2)];
                m_st[s][w] = 0;
                for (int k = 0; k < 2; k++) data_mem[s][w][k] = $urandom;
            end

        // Reset state
        tick(); tick();
        chk("rst_cctrans", {31'b0, cctrans}, 32'd0);
        chk("rst_busy", {31'b0, snp_busy}, 32'd0);
        chk("rst_dstore", dstore_snp, 32'd0);
        chk("rst_ccwrite_hi", {31'b0, ccwrite}, 32'd1);
        chk("rst_snp_addr", {28'b0, snp_set, snp_way, snp_word}, 32'd0);
        req_rdx = 0;
        #1;
        chk("rst_ccwrite_lo", {31'b0, ccwrite}, 32'd0);
        tick();
        RST = 1'b0;
        tick();
        read_all();

        // Miss on an address nobody holds
        snoop(32'h0000_1008, 1'b0, 0, 0, 1'b0, 1, 1'b0);
        read_all();

        // Clean hit with invalidate
        set_frame(1, 0, 1, TAGW'(32'h40));
        tag_mem[1][1] = TAGW'(32'h77);
        snoop(mk_addr(TAGW'(32'h40), 1, 0), 1'b1, 0, 0, 1'b0, 0, 1'b0);
        read_frame(1, 0);

        // Dirty hit, writeback, M->S; acks land in cycles 4 and 6
        data_mem[1][1][0] = 32'hDEAD_BEEF;
        data_mem[1][1][1] = 32'h1234_5678;
        set_frame(1, 1, 2, TAGW'(32'h77));
        snoop(mk_addr(TAGW'(32'h77), 1, 1), 1'b0, 1, 1, 1'b0, 2, 1'b0);
        read_frame(1, 1);

        // Same with invalidate and a competing own-FSM write during WB
        set_frame(1, 1, 2, TAGW'(32'h77));
        snoop(mk_addr(TAGW'(32'h77), 1, 0), 1'b1, 1, 1, 1'b0, 0, 1'b1);
        read_frame(1, 1);

        // ccwait dropped in LOOKUP still completes, and ack on WB entry counts
        set_frame(2, 0, 2, TAGW'(32'h1234));
        snoop(mk_addr(TAGW'(32'h1234), 2, 0), 1'b0, 0, 0, 1'b1, 0, 1'b0);

        // Reset in the middle of a writeback
        set_frame(3, 1, 2, TAGW'(32'h55));
        resp_q.push_back(1'b1);
        ccwait = 1'b1;
        ccsnoopaddr = mk_addr(TAGW'(32'h55), 3, 0);
        tick(); tick(); tick();               // now WB, cycle 3
        chk("wb_word0_held", dstore_snp, data_mem[3][1][0]);
        tick();                               // cycle 4
        RST = 1'b1;
        tick();
        chk("rst_mid_busy", {31'b0, snp_busy}, 32'd0);
        chk("rst_mid_dstore", dstore_snp, 32'd0);
        RST = 1'b0;
        ccwait = 1'b0;
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) m_st[s][w] = 0;
        tick();
        read_all();

        // Randomized traffic
        for (int it = 0; it < 80; it++) begin
            req_rdx = 1'($urandom);
            if ($urandom_range(0, 9) < 4) begin
                set_frame($urandom_range(0, SETS-1), $urandom_range(0, WAYS-1),
                          $urandom_range(0, 3), tag_pool[$urandom_range(0, 2)]);
            end else begin
                snoop(mk_addr(tag_pool[$urandom_range(0, 2)], $urandom_range(0, SETS-1), 1'($urandom)),
                      1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
                      ($urandom_range(0, 4) == 0), $urandom_range(0, 2), 1'($urandom));
                read_frame($urandom_range(0, SETS-1), $urandom_range(0, WAYS-1));
            end
        end
        read_all();

        tick();
        chk("resp_q_drained", resp_q.size(), 32'd0);
        chk("wb_q_drained", wb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
